// File: rtl/lwe_row_accumulator.sv
// lwe_row_accumulator: streams every cached public-key row out of the cache and
// sums the selected rows into one LWE ciphertext (ct_a vector, ct_b scalar).
module lwe_row_accumulator #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_ROWS   = 8,
  parameter int NUM_COLS   = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic [2:0]                     kyber_k,
  input  logic                           msg_bit,
  input  logic [NUM_ROWS-1:0]            sel_mask,
  input  logic                           cache_full,
  input  logic [NUM_COLS*DATA_WIDTH-1:0] row_in,
  input  logic [DATA_WIDTH-1:0]          sum_in,
  output logic                           encryption_req,
  output logic                           busy,
  output logic [NUM_COLS*DATA_WIDTH-1:0] ct_a,
  output logic [DATA_WIDTH-1:0]          ct_b,
  output logic                           ct_valid,
  input  logic                           ct_ready
);

  localparam int CW = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_FULL,
    S_READ,
    S_DRAIN,
    S_DONE
  } state_e;

  state_e                         state_q, state_d;
  logic [CW-1:0]                  cnt_q;       // request index issued this cycle
  logic                           rd_valid_q;  // row_in/sum_in carry a row this cycle
  logic [CW-1:0]                  rd_row_q;    // which row row_in/sum_in belong to
  logic [NUM_ROWS-1:0]            mask_q;
  logic                           msg_q;
  logic                           k3_q;        // only three columns active
  logic [NUM_COLS*DATA_WIDTH-1:0] acc_a_q, acc_a_d;
  logic [DATA_WIDTH-1:0]          acc_b_q, acc_b_d;
  logic [NUM_COLS*DATA_WIDTH-1:0] ct_a_q;
  logic [DATA_WIDTH-1:0]          ct_b_q;

  // Next-state logic for the read/accumulate sequence.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    state_d = state_q;
    unique case (state_q)
      S_IDLE:      if (start) state_d = S_WAIT_FULL;
      S_WAIT_FULL: if (cache_full) state_d = S_READ;
      S_READ:      if (cnt_q == CW'(NUM_ROWS - 1)) state_d = S_DRAIN;
      S_DRAIN:     state_d = S_DONE;
      S_DONE:      if (ct_ready) state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  // Add the row returned this cycle into the accumulators when its select bit is set.
  always_comb begin
    acc_a_d = acc_a_q;
    acc_b_d = acc_b_q;
    if (rd_valid_q && mask_q[rd_row_q]) begin
      for (int c = 0; c < NUM_COLS; c++) begin
        if (!(k3_q && c == 3)) begin
          acc_a_d[c*DATA_WIDTH +: DATA_WIDTH] =
            acc_a_q[c*DATA_WIDTH +: DATA_WIDTH] + row_in[c*DATA_WIDTH +: DATA_WIDTH];
        end
      end
      acc_b_d = acc_b_q + sum_in;
    end
  end

  // State, configuration, accumulator and result registers.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      rd_valid_q <= 1'b0;
      rd_row_q   <= '0;
      mask_q     <= '0;
      msg_q      <= 1'b0;
      k3_q       <= 1'b0;
      acc_a_q    <= '0;
      acc_b_q    <= '0;
      ct_a_q     <= '0;
      ct_b_q     <= '0;
    end else begin
      state_q <= state_d;

      // Configuration is captured only on an accepted start.
      if (state_q == S_IDLE && start) begin
        mask_q <= sel_mask;
        msg_q  <= msg_bit;
        k3_q   <= (kyber_k == 3'd3);
      end

      // Cache answers one cycle after each request, so remember what was asked.
      cnt_q      <= (state_q == S_READ) ? cnt_q + 1'b1 : '0;
      rd_valid_q <= (state_q == S_READ);
      rd_row_q   <= cnt_q;

      // The last row lands during DRAIN; fold it in while latching the result.
      if (state_q == S_DRAIN) begin
        ct_a_q <= acc_a_d;
        ct_b_q <= acc_b_d + {msg_q, {(DATA_WIDTH-1){1'b0}}};
      end

      if (state_q == S_DONE && ct_ready) begin
        acc_a_q <= '0;
        acc_b_q <= '0;
      end else begin
        acc_a_q <= acc_a_d;
        acc_b_q <= acc_b_d;
      end
    end
  end

  assign encryption_req = (state_q == S_READ);
  assign busy           = (state_q != S_IDLE);
  assign ct_valid       = (state_q == S_DONE);
  assign ct_a           = ct_a_q;
  assign ct_b           = ct_b_q;

endmodule
